// File: rtl/pc_fetch_queue_pkg.sv
// Shared definitions for the prefetching fetch queue: hold levels, bus tie-offs and counter sizing.
// The optional FETCH_BYPASS_EN macro is consumed by pc_fetch_queue.sv.
package pc_fetch_queue_pkg;

   localparam int HOLD_FLAG_W = 3;

   typedef enum logic [HOLD_FLAG_W-1:0] {
      HOLD_NONE = 3'b000,
      HOLD_PC   = 3'b001,
      HOLD_IF   = 3'b010,
      HOLD_ID   = 3'b011
   } hold_e;

   localparam logic       WRITE_DISABLE = 1'b0;
   localparam logic [3:0] BYTE_EN_NONE  = 4'h0;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pc_fetch_queue_if.sv
// Icache master/slave port of the fetch queue; the fetcher takes the master modport.
interface pc_fetch_queue_if #(
   parameter int DATA_W       = 32,
   parameter int CACHE_ADDR_W = 25
);
   logic [CACHE_ADDR_W-1:0] o_p_addr;
   logic [3:0]              o_p_byte_en;
   logic [DATA_W-1:0]       o_p_writedata;
   logic                    o_p_read;
   logic                    o_p_write;
   logic [DATA_W-1:0]       i_p_readdata;
   logic                    i_p_readdata_valid;
   logic                    i_p_waitrequest;

   modport master (
      output o_p_addr, o_p_byte_en, o_p_writedata, o_p_read, o_p_write,
      input  i_p_readdata, i_p_readdata_valid, i_p_waitrequest
   );

   modport slave (
      input  o_p_addr, o_p_byte_en, o_p_writedata, o_p_read, o_p_write,
      output i_p_readdata, i_p_readdata_valid, i_p_waitrequest
   );
endinterface

// File: rtl/pc_fetch_queue_fetch_fifo.sv
// In-order instruction buffer holding {addr, data} entries; flush empties it in one cycle.
module fetch_fifo #(
   parameter int  WIDTH = 64,
   parameter int  DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);

endmodule

// File: rtl/pc_fetch_queue.sv
// Prefetching fetch unit: credit-limited icache reads feeding an in-order FIFO, with jump flush.
// Define FETCH_BYPASS_EN to let a response skip the empty FIFO straight into the output register.
module pc_fetch_queue
   import pc_fetch_queue_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int CACHE_ADDR_W    = 25,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_INC        = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   jtag_reset_flag_i,
   input  logic                   jump_flag_i,
   input  logic [ADDR_W-1:0]      jump_addr_i,
   input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
   output logic [ADDR_W-1:0]      inst_addr_o,
   output logic [DATA_W-1:0]      inst_o,
   output logic                   inst_valid,
   pc_fetch_queue_if.master       cache
);

   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam int FW = CACHE_ADDR_W - 2;
   localparam int EW = ADDR_W + DATA_W;

   logic              sys_rst;
   logic [FW-1:0]     fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit_sum;
   logic              fifo_full;
   logic              fifo_empty;
   logic              issue;
   logic              resp;
   logic              accept;
   logic              held;
   logic              pop;
   logic              push;
   logic              bypass;
   logic [EW-1:0]     head;

   assign sys_rst    = rst | jtag_reset_flag_i;
   assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
   assign resp       = cache.i_p_readdata_valid;
   assign held       = (hold_flag_i > HOLD_PC);

   // Every FIFO slot is reserved by either a buffered word or a read still in flight.
   assign issue  = !sys_rst && !jump_flag_i && !cache.i_p_waitrequest
                   && (credit_sum < (CW+1)'(FIFO_DEPTH))
                   && (outstanding < CW'(MAX_OUTSTANDING));
   assign accept = resp && !jump_flag_i && (drop_cnt == '0);
   assign pop    = !fifo_empty && !held && !jump_flag_i;

`ifdef FETCH_BYPASS_EN
   assign bypass = accept && fifo_empty && !held;
`else
   assign bypass = 1'b0;
`endif

   assign push = accept && !bypass;

   assign cache.o_p_addr      = {2'b00, fetch_pc};
   assign cache.o_p_byte_en   = BYTE_EN_NONE;
   assign cache.o_p_writedata = '0;
   assign cache.o_p_read      = issue;
   assign cache.o_p_write     = WRITE_DISABLE;

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (sys_rst),
      .push      (push),
      .push_data ({resp_pc, cache.i_p_readdata}),
      .pop       (pop),
      .pop_data  (head),
      .flush     (jump_flag_i),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // A jump must drop whatever is still in flight, minus a response landing in the jump cycle itself.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         fetch_pc    <= '0;
         resp_pc     <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(resp);
         if (jump_flag_i) begin
            fetch_pc <= jump_addr_i[FW-1:0];
            resp_pc  <= jump_addr_i;
            drop_cnt <= outstanding - CW'(resp);
         end else begin
            if (issue)                    fetch_pc <= fetch_pc + FW'(ADDR_INC);
            if (resp && drop_cnt != '0)   drop_cnt <= drop_cnt - CW'(1);
            if (accept)                   resp_pc  <= resp_pc + ADDR_W'(ADDR_INC);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst || jump_flag_i) begin
         inst_valid  <= 1'b0;
         inst_addr_o <= '0;
         inst_o      <= '0;
      end else if (pop) begin
         inst_valid                <= 1'b1;
         {inst_addr_o, inst_o}     <= head;
      end else if (bypass) begin
         inst_valid  <= 1'b1;
         inst_addr_o <= resp_pc;
         inst_o      <= cache.i_p_readdata;
      end else begin
         inst_valid  <= 1'b0;
         inst_addr_o <= '0;
         inst_o      <= '0;
      end
   end

   no_push_when_full: assert property (@(posedge clk) disable iff (sys_rst)
      !(push && fifo_full));

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Scoreboard bench for pc_fetch_queue: an icache model answers in order, a monitor checks the delivered stream.
module tb_pc_fetch_queue;
   import pc_fetch_queue_pkg::*;

`ifdef FETCH_BYPASS_EN
   localparam int FIRST_LAT = 3;
`else
   localparam int FIRST_LAT = 4;
`endif

   typedef struct {
      logic [24:0] addr;
      int          due;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        jtag;
   logic        jump;
   logic [31:0] jump_addr;
   logic [2:0]  hold;
   logic [31:0] inst_addr_o;
   logic [31:0] inst_o;
   logic        inst_valid;

   req_t        pend[$];
   logic [31:0] expq[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          lat = 1;
   int          valid_seen = 0;
   logic [31:0] exp_fetch = '0;

   pc_fetch_queue_if #(.DATA_W(32), .CACHE_ADDR_W(25)) cache_bus ();

   pc_fetch_queue u_dut (
      .clk               (clk),
      .rst               (rst),
      .jtag_reset_flag_i (jtag),
      .jump_flag_i       (jump),
      .jump_addr_i       (jump_addr),
      .hold_flag_i       (hold),
      .inst_addr_o       (inst_addr_o),
      .inst_o            (inst_o),
      .inst_valid        (inst_valid),
      .cache             (cache_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [24:0] a);
      return 32'hC000_0000 | {7'h00, a};
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(posedge clk);
      #3;
   endtask

   task automatic apply_stimulus(input logic [31:0] base);
      expq.delete();
      for (int i = 0; i < 128; i++) expq.push_back(base + i);
   endtask

   task automatic wait_valids(input int n, input string name);
      int target;
      int t;
      target = valid_seen + n;
      t = 0;
      while (valid_seen < target && t < 200) begin
         sample();
         t++;
      end
      check_output(name, 32'(valid_seen >= target), 32'd1);
   endtask

   // Called at +3 of the first cycle after reset release; counts cycles up to the first delivery.
   task automatic measure_first(input string name);
      int n;
      n = 1;
      while (!inst_valid && n < 20) begin
         sample();
         n++;
      end
      check_output(name, 32'(n), 32'(FIRST_LAT));
   endtask

   task automatic wait_two_outstanding(input string name);
      int t;
      t = 0;
      sample();
      while ((pend.size() + int'(cache_bus.o_p_read)) != 2 && t < 30) begin
         sample();
         t++;
      end
      check_output(name, 32'(pend.size() + int'(cache_bus.o_p_read)), 32'd2);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Icache model: in-order answers, one per cycle, no earlier than lat cycles after the request.
   always @(posedge clk) begin
      #2;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         cache_bus.i_p_readdata_valid = 1'b1;
         cache_bus.i_p_readdata       = data_of(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         cache_bus.i_p_readdata_valid = 1'b0;
         cache_bus.i_p_readdata       = '0;
      end
   end

   // Request capture and delivery scoreboard.
   always @(negedge clk) begin
      logic [31:0] e;
      if (cache_bus.o_p_read) begin
         check_output("req_addr", 32'(cache_bus.o_p_addr), {9'd0, exp_fetch[22:0]});
         pend.push_back('{cache_bus.o_p_addr, cyc + lat});
         exp_fetch = exp_fetch + 1;
      end
      if (inst_valid) begin
         valid_seen++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: got addr %h expected none", inst_addr_o);
         end else begin
            e = expq.pop_front();
            check_output("inst_addr", inst_addr_o, e);
            check_output("inst_data", inst_o, data_of({2'b00, e[22:0]}));
         end
      end else begin
         check_output("idle_zero", inst_addr_o | inst_o, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gaps;
      int run;
      int exp_drop;
      int exp_drop2;
      rst = 1'b1;
      jtag = 1'b0;
      jump = 1'b0;
      jump_addr = '0;
      hold = HOLD_NONE;
      cache_bus.i_p_waitrequest = 1'b0;
      cache_bus.i_p_readdata_valid = 1'b0;
      cache_bus.i_p_readdata = '0;
      lat = 1;

      repeat (3) drive_edge();
      #2;
      check_output("rst_valid", 32'(inst_valid), 32'd0);
      check_output("rst_addr", inst_addr_o, 32'd0);
      check_output("rst_inst", inst_o, 32'd0);
      check_output("rst_read", 32'(cache_bus.o_p_read), 32'd0);
      check_output("rst_p_addr", 32'(cache_bus.o_p_addr), 32'd0);
      check_output("tie_byte_en", 32'(cache_bus.o_p_byte_en), 32'd0);
      check_output("tie_write", 32'(cache_bus.o_p_write), 32'd0);
      check_output("tie_wdata", cache_bus.o_p_writedata, 32'd0);

      // Streaming from reset.
      drive_edge();
      rst = 1'b0;
      apply_stimulus(32'h0);
      exp_fetch = '0;
      #2;
      measure_first("first_valid_lat");
      gaps = 0;
      repeat (12) begin
         sample();
         if (!inst_valid) gaps++;
      end
      check_output("steady_no_gaps", 32'(gaps), 32'd0);

      // Hold fills the buffer and chokes issue.
      drive_edge();
      hold = HOLD_IF;
      repeat (9) drive_edge();
      #2;
      check_output("hold_no_read", 32'(cache_bus.o_p_read), 32'd0);
      check_output("hold_fifo_full", 32'(u_dut.u_fifo.count), 32'd4);
      check_output("hold_none_inflight", 32'(pend.size()), 32'd0);
      drive_edge();
      hold = HOLD_NONE;
      run = 0;
      repeat (4) begin
         sample();
         if (inst_valid) run++;
      end
      check_output("hold_release_burst", 32'(run), 32'd4);

      // Hold level equal to HOLD_PC does not stall delivery.
      drive_edge();
      hold = HOLD_PC;
      gaps = 0;
      repeat (6) begin
         sample();
         if (!inst_valid) gaps++;
      end
      check_output("hold_pc_no_stall", 32'(gaps), 32'd0);
      drive_edge();
      hold = HOLD_NONE;

      // Jump with two reads in flight.
      lat = 3;
      wait_two_outstanding("two_outstanding_a");
      drive_edge();
      jump = 1'b1;
      jump_addr = 32'h40;
      exp_fetch = 32'h40;
      #2;
      check_output("jump_no_issue", 32'(cache_bus.o_p_read), 32'd0);
      exp_drop = pend.size();
      drive_edge();
      jump = 1'b0;
      apply_stimulus(32'h40);
      #2;
      check_output("drop_cnt_jump", 32'(u_dut.drop_cnt), 32'(exp_drop));
      wait_valids(6, "post_jump_stream");

      // Jump coinciding with a response and a would-be issue, then back-to-back jumps.
      lat = 1;
      repeat (6) sample();
      drive_edge();
      jump = 1'b1;
      jump_addr = 32'h80;
      exp_fetch = 32'h80;
      #2;
      check_output("jump_resp_present", 32'(cache_bus.i_p_readdata_valid), 32'd1);
      check_output("jump_resp_no_issue", 32'(cache_bus.o_p_read), 32'd0);
      exp_drop = pend.size();
      drive_edge();
      jump_addr = 32'h200;
      exp_fetch = 32'h200;
      #2;
      check_output("drop_cnt_resp_jump", 32'(u_dut.drop_cnt), 32'(exp_drop));
      exp_drop2 = pend.size();
      drive_edge();
      jump = 1'b0;
      apply_stimulus(32'h200);
      #2;
      check_output("drop_cnt_b2b", 32'(u_dut.drop_cnt), 32'(exp_drop2));
      wait_valids(6, "post_b2b_stream");

      // Wait-request stall keeps the address steady.
      drive_edge();
      cache_bus.i_p_waitrequest = 1'b1;
      #2;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) sample();
         check_output("wait_no_read", 32'(cache_bus.o_p_read), 32'd0);
         check_output("wait_addr_hold", 32'(cache_bus.o_p_addr), {9'd0, exp_fetch[22:0]});
      end
      drive_edge();
      cache_bus.i_p_waitrequest = 1'b0;
      #2;
      check_output("wait_resume_read", 32'(cache_bus.o_p_read), 32'd1);
      check_output("wait_resume_addr", 32'(cache_bus.o_p_addr), {9'd0, exp_fetch[22:0]});
      wait_valids(4, "post_wait_stream");

      // JTAG reset pulse with reads in flight.
      lat = 3;
      wait_two_outstanding("two_outstanding_b");
      drive_edge();
      jtag = 1'b1;
      pend.delete();
      lat = 1;
      drive_edge();
      jtag = 1'b0;
      apply_stimulus(32'h0);
      exp_fetch = '0;
      #2;
      check_output("jtag_valid", 32'(inst_valid), 32'd0);
      check_output("jtag_addr", inst_addr_o, 32'd0);
      check_output("jtag_inst", inst_o, 32'd0);
      check_output("jtag_p_addr", 32'(cache_bus.o_p_addr), 32'd0);
      measure_first("jtag_first_valid_lat");
      wait_valids(8, "post_jtag_stream");

      repeat (3) sample();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
